// File: rtl/write_back_register_file_if.sv
// Writeback-stage bundle: MEM/WB payload into the register file, read ports and status back out.
interface write_back_register_file_if #(parameter int XLEN = 32);
  logic            writeBackValid;
  logic            regWriteEnable;
  logic [1:0]      writeBackSelect;
  logic [2:0]      loadFunct3;
  logic [1:0]      loadAddressLow;
  logic [XLEN-1:0] memoryReadData;
  logic [XLEN-1:0] aluData;
  logic [XLEN-1:0] pcPlus4;
  logic [4:0]      destinationRegister;
  logic [4:0]      readAddress1;
  logic [4:0]      readAddress2;
  logic [XLEN-1:0] readData1;
  logic [XLEN-1:0] readData2;
  logic [XLEN-1:0] writeBackData;
  logic            writeBackActive;
  logic [63:0]     retiredCount;

  // No handshake: every input is sampled at each rising edge, every output is combinational
  // from the current inputs plus the stored registers/counter.
  modport master (
    output writeBackValid, regWriteEnable, writeBackSelect, loadFunct3, loadAddressLow,
           memoryReadData, aluData, pcPlus4, destinationRegister, readAddress1, readAddress2,
    input  readData1, readData2, writeBackData, writeBackActive, retiredCount
  );

  modport slave (
    input  writeBackValid, regWriteEnable, writeBackSelect, loadFunct3, loadAddressLow,
           memoryReadData, aluData, pcPlus4, destinationRegister, readAddress1, readAddress2,
    output readData1, readData2, writeBackData, writeBackActive, retiredCount
  );
endinterface

// File: rtl/write_back_register_file.sv
// RV32I writeback stage: load formatting, writeback mux, 32-entry register file with
// same-cycle write-to-read bypass, and a 64-bit retired-instruction counter.
module write_back_register_file #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input logic                          clock,
  input logic                          reset,
  write_back_register_file_if.slave    wb
);

  logic [XLEN-1:0] regs [REG_COUNT];
  logic [63:0]     retiredCounter;
  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] writeData;
  logic            writeActive;

  always_comb begin
    loadByte = wb.memoryReadData[7:0];
    case (wb.loadAddressLow)
      2'd0: loadByte = wb.memoryReadData[7:0];
      2'd1: loadByte = wb.memoryReadData[15:8];
      2'd2: loadByte = wb.memoryReadData[23:16];
      2'd3: loadByte = wb.memoryReadData[31:24];
      default: loadByte = wb.memoryReadData[7:0];
    endcase
    // Half-word alignment ignores address bit 0.
    loadHalf = wb.loadAddressLow[1] ? wb.memoryReadData[31:16] : wb.memoryReadData[15:0];

    loadData = wb.memoryReadData;
    case (wb.loadFunct3)
      3'b000: loadData = {{(XLEN-8){loadByte[7]}}, loadByte};
      3'b001: loadData = {{(XLEN-16){loadHalf[15]}}, loadHalf};
      3'b100: loadData = {{(XLEN-8){1'b0}}, loadByte};
      3'b101: loadData = {{(XLEN-16){1'b0}}, loadHalf};
      default: loadData = wb.memoryReadData;
    endcase
  end

  always_comb begin
    writeData = wb.aluData;
    case (wb.writeBackSelect)
      2'b01:   writeData = loadData;
      2'b10:   writeData = wb.pcPlus4;
      default: writeData = wb.aluData;
    endcase
  end

  assign writeActive = wb.writeBackValid & wb.regWriteEnable &
                       (wb.destinationRegister != 5'd0) & ~reset;

  function automatic logic [XLEN-1:0] readPort(input logic [4:0] address);
    if (reset || address == 5'd0)
      return '0;
    else if (writeActive && address == wb.destinationRegister)
      return writeData;
    else
      return regs[address];
  endfunction

  assign wb.readData1       = readPort(wb.readAddress1);
  assign wb.readData2       = readPort(wb.readAddress2);
  assign wb.writeBackData   = writeData;
  assign wb.writeBackActive = writeActive;
  assign wb.retiredCount    = retiredCounter;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      retiredCounter <= '0;
    end else begin
      if (writeActive) regs[wb.destinationRegister] <= writeData;
      if (wb.writeBackValid) retiredCounter <= retiredCounter + 64'd1;
    end
  end

endmodule
